// File: rtl/cpu_pkg.sv
// Shared types and field positions for the multi-cycle sequencer.
// Imported by the decoder and by the controller top.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'h0,
        OP_MOV_AB = 4'h1,
        OP_IN_A   = 4'h2,
        OP_MOV_AI = 4'h3,
        OP_MOV_BA = 4'h4,
        OP_ADD_B  = 4'h5,
        OP_IN_B   = 4'h6,
        OP_MOV_BI = 4'h7,
        OP_NOP_8  = 4'h8,
        OP_OUT_B  = 4'h9,
        OP_NOP_A  = 4'hA,
        OP_OUT_I  = 4'hB,
        OP_NOP_C  = 4'hC,
        OP_NOP_D  = 4'hD,
        OP_JNC    = 4'hE,
        OP_JMP    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_IN   = 2'b10,
        SEL_ZERO = 2'b11
    } sel_e;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_e;

    localparam int OPC_W   = 4;
    localparam int IMM_LSB = 0;

    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_W   = 3;

    // Opcode sits directly above the immediate field.
    function automatic int opc_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/cpu_ctrl_insn_decode.sv
// Combinational opcode decoder: operand select, load vector
// and jump control for the EXEC cycle.
module insn_decode
    import cpu_pkg::*;
(
    input  opcode_e          opcode,
    input  logic             cf,
    output sel_e             sel,
    output logic [LD_W-1:0]  ld,
    output logic             is_add,
    output logic             is_jmp,
    output logic             jmp_taken
);

    always_comb begin
        sel       = SEL_ZERO;
        ld        = '0;
        is_add    = 1'b0;
        is_jmp    = 1'b0;
        jmp_taken = 1'b0;
        unique case (opcode)
            OP_ADD_A: begin
                sel       = SEL_A;
                ld[LD_A]  = 1'b1;
                is_add    = 1'b1;
            end
            OP_MOV_AB: begin
                sel       = SEL_B;
                ld[LD_A]  = 1'b1;
            end
            OP_IN_A: begin
                sel       = SEL_IN;
                ld[LD_A]  = 1'b1;
            end
            OP_MOV_AI: begin
                sel       = SEL_ZERO;
                ld[LD_A]  = 1'b1;
            end
            OP_MOV_BA: begin
                sel       = SEL_A;
                ld[LD_B]  = 1'b1;
            end
            OP_ADD_B: begin
                sel       = SEL_B;
                ld[LD_B]  = 1'b1;
                is_add    = 1'b1;
            end
            OP_IN_B: begin
                sel       = SEL_IN;
                ld[LD_B]  = 1'b1;
            end
            OP_MOV_BI: begin
                sel       = SEL_ZERO;
                ld[LD_B]  = 1'b1;
            end
            OP_OUT_B: begin
                sel        = SEL_B;
                ld[LD_OUT] = 1'b1;
            end
            OP_OUT_I: begin
                sel        = SEL_ZERO;
                ld[LD_OUT] = 1'b1;
            end
            // JNC looks at the flag as it stood before this EXEC.
            OP_JNC: begin
                is_jmp    = 1'b1;
                jmp_taken = ~cf;
            end
            OP_JMP: begin
                is_jmp    = 1'b1;
                jmp_taken = 1'b1;
            end
            OP_NOP_8, OP_NOP_A, OP_NOP_C, OP_NOP_D: begin
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Two-phase FETCH/EXEC sequencer: PC, IR, carry flag, halt
// detect and phase-gated register load enables.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic                C,
    input  logic                n_rst,
    input  logic                en,
    input  logic [3+DATA_W:0]   insn,
    input  logic                alu_c,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   imm,
    output logic                ld_a,
    output logic                ld_b,
    output logic                ld_out,
    output logic                phase,
    output logic                halted
);

    localparam int OPC_LSB = opc_lsb(DATA_W);

    phase_e              state;
    logic [ADDR_W-1:0]   pc;
    logic [3+DATA_W:0]   ir;
    logic                cf;
    logic                halt_q;

    opcode_e             opc;
    sel_e                dsel;
    logic [LD_W-1:0]     dld;
    logic                is_add;
    logic                is_jmp;
    logic                jmp_taken;

    logic [ADDR_W-1:0]   tgt;
    logic [ADDR_W-1:0]   pc_inc;
    logic                take;
    logic                self_loop;

    assign opc = opcode_e'(ir[OPC_LSB +: OPC_W]);

    insn_decode u_dec (
        .opcode    (opc),
        .cf        (cf),
        .sel       (dsel),
        .ld        (dld),
        .is_add    (is_add),
        .is_jmp    (is_jmp),
        .jmp_taken (jmp_taken)
    );

    assign tgt       = ADDR_W'(ir[IMM_LSB +: DATA_W]);
    assign pc_inc    = pc + ADDR_W'(1);
    assign take      = is_jmp & jmp_taken;
    assign self_loop = take & (tgt == pc);

    always_ff @(posedge C or negedge n_rst) begin
        if (!n_rst) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            cf     <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (en && !halt_q) begin
                        ir    <= insn;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    pc    <= take ? tgt : pc_inc;
                    cf    <= is_add ? alu_c : 1'b0;
                    state <= FETCH;
                    if (self_loop) begin
                        halt_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // sel/imm track the IR in both phases; only loads are gated.
    assign rom_addr = pc;
    assign sel      = dsel;
    assign imm      = ir[IMM_LSB +: DATA_W];
    assign phase    = (state == EXEC);
    assign ld_a     = phase & dld[LD_A];
    assign ld_b     = phase & dld[LD_B];
    assign ld_out   = phase & dld[LD_OUT];
    assign halted   = halt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a behavioural reference model
// compared on every falling clock edge.
module tb_cpu_ctrl;

    logic       C;
    logic       n_rst;
    logic       en;
    logic [7:0] insn;
    logic       alu_c;
    logic [3:0] rom_addr;
    logic [1:0] sel;
    logic [3:0] imm;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       phase;
    logic       halted;

    logic [7:0] rom [16];
    int         checks = 0;
    int         errors = 0;
    bit         armed  = 0;
    int         pc_now;

    cpu_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .C        (C),
        .n_rst    (n_rst),
        .en       (en),
        .insn     (insn),
        .alu_c    (alu_c),
        .rom_addr (rom_addr),
        .sel      (sel),
        .imm      (imm),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .ld_out   (ld_out),
        .phase    (phase),
        .halted   (halted)
    );

    assign insn = rom[rom_addr];

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    // Reference tables by opcode; -1 marks an unspecified select.
    int sel_tab [16] = '{0, 1, 2, 3, 0, 1, 2, 3,
                         -1, 1, -1, 3, -1, -1, -1, -1};
    int ld_tab  [16] = '{1, 1, 1, 1, 2, 2, 2, 2,
                         0, 4, 0, 4, 0, 0, 0, 0};

    int         m_pc;
    logic [7:0] m_ir;
    bit         m_cf;
    bit         m_halt;
    bit         m_ph;

    function automatic bit taken_f(input logic [7:0] ir, input bit cf);
        return (ir[7:4] == 4'hF) || (ir[7:4] == 4'hE && !cf);
    endfunction

    function automatic bit is_add_f(input logic [7:0] ir);
        return (ir[7:4] == 4'h0) || (ir[7:4] == 4'h5);
    endfunction

    always @(posedge C or negedge n_rst) begin
        if (!n_rst) begin
            m_pc   <= 0;
            m_ir   <= 8'h00;
            m_cf   <= 1'b0;
            m_halt <= 1'b0;
            m_ph   <= 1'b0;
        end else if (!m_ph) begin
            if (en && !m_halt) begin
                m_ir <= rom[m_pc];
                m_ph <= 1'b1;
            end
        end else begin
            if (taken_f(m_ir, m_cf)) begin
                m_pc <= int'(m_ir[3:0]);
                if (int'(m_ir[3:0]) == m_pc) m_halt <= 1'b1;
            end else begin
                m_pc <= (m_pc + 1) % 16;
            end
            m_cf <= is_add_f(m_ir) ? alu_c : 1'b0;
            m_ph <= 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge C) begin
        if (armed) begin
            chk("model rom_addr", int'(rom_addr), m_pc);
            chk("model phase", int'(phase), int'(m_ph));
            chk("model halted", int'(halted), int'(m_halt));
            chk("model imm", int'(imm), int'(m_ir[3:0]));
            chk("model ld", int'({ld_out, ld_b, ld_a}),
                m_ph ? ld_tab[m_ir[7:4]] : 0);
            if (sel_tab[m_ir[7:4]] >= 0)
                chk("model sel", int'(sel), sel_tab[m_ir[7:4]]);
        end
    end

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        @(negedge C);
        #1 n_rst = 1'b0;
        repeat (3) @(negedge C);
        chk("rst rom_addr", int'(rom_addr), 0);
        chk("rst phase", int'(phase), 0);
        chk("rst ld", int'({ld_out, ld_b, ld_a}), 0);
        chk("rst sel", int'(sel), 0);
        chk("rst imm", int'(imm), 0);
        chk("rst halted", int'(halted), 0);
        #1 n_rst = 1'b1;
        armed = 1'b1;
    endtask

    // Starts just after a FETCH-phase negedge, ends at the next one.
    task automatic run_insn(input bit c, output int pc_after);
        @(negedge C);
        #1 alu_c = c;
        @(negedge C);
        pc_after = int'(rom_addr);
    endtask

    initial begin
        n_rst = 1'b1;
        en    = 1'b0;
        alu_c = 1'b0;
        fill_rom(8'h00);

        // Counting with ADD A,0 and wrap at 0xF.
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge C);
            chk("count exec phase", int'(phase), 1);
            chk("count ld_a", int'(ld_a), 1);
            chk("count exec pc", int'(rom_addr), i % 16);
            @(negedge C);
            chk("count fetch ld_a", int'(ld_a), 0);
            chk("count fetch pc", int'(rom_addr), (i + 1) % 16);
        end

        // Decode sweep.
        fill_rom(8'h80);
        rom[0] = 8'h35;
        rom[1] = 8'h10;
        rom[2] = 8'h47;
        rom[3] = 8'h92;
        rom[4] = 8'hB3;
        do_reset();
        @(negedge C);
        chk("dec 35 ld", int'({ld_out, ld_b, ld_a}), 1);
        chk("dec 35 sel", int'(sel), 3);
        chk("dec 35 imm", int'(imm), 5);
        @(negedge C);
        @(negedge C);
        chk("dec 10 ld", int'({ld_out, ld_b, ld_a}), 1);
        chk("dec 10 sel", int'(sel), 1);
        @(negedge C);
        @(negedge C);
        chk("dec 47 ld", int'({ld_out, ld_b, ld_a}), 2);
        chk("dec 47 sel", int'(sel), 0);
        @(negedge C);
        @(negedge C);
        chk("dec 92 ld", int'({ld_out, ld_b, ld_a}), 4);
        chk("dec 92 sel", int'(sel), 1);
        @(negedge C);
        @(negedge C);
        chk("dec B3 ld", int'({ld_out, ld_b, ld_a}), 4);
        chk("dec B3 sel", int'(sel), 3);
        chk("dec B3 imm", int'(imm), 3);
        @(negedge C);
        chk("dec B3 fetch sel", int'(sel), 3);
        chk("dec B3 fetch ld", int'({ld_out, ld_b, ld_a}), 0);

        // Carry flag and JNC.
        fill_rom(8'h80);
        rom[0]  = 8'h01;
        rom[1]  = 8'hE8;
        rom[2]  = 8'h01;
        rom[3]  = 8'hE8;
        rom[8]  = 8'h01;
        rom[9]  = 8'h30;
        rom[10] = 8'hEC;
        do_reset();
        run_insn(1'b1, pc_now);
        chk("cy add pc", pc_now, 1);
        run_insn(1'b0, pc_now);
        chk("cy jnc not taken", pc_now, 2);
        run_insn(1'b0, pc_now);
        chk("cy add2 pc", pc_now, 3);
        run_insn(1'b0, pc_now);
        chk("cy jnc taken", pc_now, 8);
        run_insn(1'b1, pc_now);
        chk("cy add3 pc", pc_now, 9);
        run_insn(1'b0, pc_now);
        chk("cy mov pc", pc_now, 10);
        run_insn(1'b0, pc_now);
        chk("cy jnc after mov", pc_now, 12);
        chk("cy no halt", int'(halted), 0);

        // Halt on JMP to own address.
        fill_rom(8'h80);
        rom[6] = 8'hF6;
        do_reset();
        for (int i = 0; i < 7; i++) run_insn(1'b0, pc_now);
        chk("halt set", int'(halted), 1);
        chk("halt pc", pc_now, 6);
        repeat (6) begin
            @(negedge C);
            chk("halt phase", int'(phase), 0);
            chk("halt pc hold", int'(rom_addr), 6);
        end
        do_reset();
        chk("halt cleared", int'(halted), 0);

        // Stall by dropping en during EXEC.
        fill_rom(8'h80);
        rom[1] = 8'h57;
        do_reset();
        run_insn(1'b0, pc_now);
        @(negedge C);
        chk("stall ld_b", int'(ld_b), 1);
        #1 en = 1'b0;
        @(negedge C);
        chk("stall done pc", int'(rom_addr), 2);
        chk("stall done phase", int'(phase), 0);
        repeat (4) begin
            @(negedge C);
            chk("stall hold pc", int'(rom_addr), 2);
            chk("stall hold phase", int'(phase), 0);
            chk("stall hold imm", int'(imm), 7);
        end
        #1 en = 1'b1;
        @(negedge C);
        chk("resume phase", int'(phase), 1);
        chk("resume pc", int'(rom_addr), 2);
        chk("resume imm", int'(imm), 0);
        @(negedge C);
        chk("resume next pc", int'(rom_addr), 3);

        // Asynchronous reset in the middle of EXEC.
        fill_rom(8'h80);
        rom[1] = 8'h60;
        do_reset();
        run_insn(1'b0, pc_now);
        @(negedge C);
        chk("async pre ld_b", int'(ld_b), 1);
        chk("async pre pc", int'(rom_addr), 1);
        #2 n_rst = 1'b0;
        #1;
        chk("async ld_b", int'(ld_b), 0);
        chk("async pc", int'(rom_addr), 0);
        chk("async phase", int'(phase), 0);
        @(negedge C);
        #1 n_rst = 1'b1;
        @(negedge C);
        chk("async restart phase", int'(phase), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
